// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared states, keycodes and helpers for the paddle controller
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    BRAKE = 2'd3
  } paddle_state_e;

  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_UP   = 8'h52;
  localparam logic [7:0] KEY_DOWN = 8'h51;

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] max_s);
    sat_inc = (s >= max_s) ? max_s : s + 4'd1;
  endfunction

endpackage

// File: rtl/paddle_ctrl_frame_tick_sync.sv
// rtl/paddle_ctrl_frame_tick_sync.sv - frame clock synchronizer producing a one-cycle tick per rising edge
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic tick_o
);

  logic s1_q, s2_q, s3_q;

  // Reset high so a frame clock already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - keyboard paddle with per-frame accelerate/brake velocity and screen clamping
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int X_POS     = 20,
  parameter int Y_CENTER  = 240,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int SIZE      = 24,
  parameter int MAX_SPEED = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] PaddleX,
  output logic [9:0] PaddleY,
  output logic [9:0] PaddleS,
  output logic [9:0] PaddleVY
);

  localparam logic [3:0]        MAX_SP = 4'(MAX_SPEED);
  localparam logic signed [10:0] Y_TOP = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_BOT = 11'(Y_MAX - SIZE);

  paddle_state_e state_q, state_d;
  logic [3:0]    speed_q, speed_d;
  logic          dir_q, dir_d;
  logic [9:0]    y_q, y_d;
  logic [9:0]    vy_q, vy_d;

  logic tick;
  logic raw_up, raw_down, key_up, key_down;
  logic signed [10:0] step, y_new;
  logic [9:0] mag;

  frame_tick_sync u_sync (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .async_i (frame_clk),
    .tick_o  (tick)
  );

  assign raw_up   = (keycode0 == KEY_W) || (keycode0 == KEY_UP) ||
                    (keycode1 == KEY_W) || (keycode1 == KEY_UP);
  assign raw_down = (keycode0 == KEY_S) || (keycode0 == KEY_DOWN) ||
                    (keycode1 == KEY_S) || (keycode1 == KEY_DOWN);
  assign key_up   = raw_up & ~raw_down;
  assign key_down = raw_down & ~raw_up;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    y_d     = y_q;
    vy_d    = vy_q;
    step    = '0;
    y_new   = '0;
    mag     = '0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (key_up) begin
            state_d = UP;
            speed_d = 4'd1;
            dir_d   = 1'b0;
          end else if (key_down) begin
            state_d = DOWN;
            speed_d = 4'd1;
            dir_d   = 1'b1;
          end else begin
            speed_d = 4'd0;
          end
        end
        UP: begin
          if (key_up) speed_d = sat_inc(speed_q, MAX_SP);
          else begin
            state_d = BRAKE;
            speed_d = speed_q - 4'd1;
          end
        end
        DOWN: begin
          if (key_down) speed_d = sat_inc(speed_q, MAX_SP);
          else begin
            state_d = BRAKE;
            speed_d = speed_q - 4'd1;
          end
        end
        BRAKE: begin
          // Only the key matching the current direction resumes; the opposite key just brakes.
          if ((dir_q && key_down) || (!dir_q && key_up)) begin
            state_d = dir_q ? DOWN : UP;
            speed_d = sat_inc(speed_q, MAX_SP);
          end else begin
            speed_d = speed_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          speed_d = 4'd0;
        end
      endcase

      if (speed_d == 4'd0) state_d = IDLE;

      step  = signed'({7'b0, speed_d});
      y_new = dir_d ? signed'({1'b0, y_q}) + step : signed'({1'b0, y_q}) - step;

      if (y_new < Y_TOP) begin
        y_d     = Y_TOP[9:0];
        speed_d = 4'd0;
        state_d = IDLE;
      end else if (y_new > Y_BOT) begin
        y_d     = Y_BOT[9:0];
        speed_d = 4'd0;
        state_d = IDLE;
      end else begin
        y_d = y_new[9:0];
      end

      mag  = {6'b0, speed_d};
      vy_d = dir_d ? mag : (~mag + 10'd1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      speed_q <= 4'd0;
      dir_q   <= 1'b0;
      y_q     <= 10'(Y_CENTER);
      vy_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
    end
  end

  assign PaddleX  = 10'(X_POS);
  assign PaddleS  = 10'(SIZE);
  assign PaddleY  = y_q;
  assign PaddleVY = vy_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - directed self-checking bench for paddle_ctrl
module tb_paddle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode0, keycode1;
  logic [9:0] PaddleX, PaddleY, PaddleS, PaddleVY;

  int total = 0;
  int bad   = 0;

  paddle_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .PaddleX   (PaddleX),
    .PaddleY   (PaddleY),
    .PaddleS   (PaddleS),
    .PaddleVY  (PaddleVY)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b1;
    keycode0  = 8'h00;
    keycode1  = 8'h00;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  logic [9:0] exp_vy_up[8] = '{10'(-1), 10'(-2), 10'(-3), 10'(-4), 10'(-5), 10'(-6), 10'(-6), 10'(-6)};
  logic [9:0] exp_y_up[8]  = '{10'd239, 10'd237, 10'd234, 10'd230, 10'd225, 10'd219, 10'd213, 10'd207};
  logic [9:0] exp_vy_br[6] = '{10'(-5), 10'(-4), 10'(-3), 10'(-2), 10'(-1), 10'd0};

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b1;
    keycode0  = 8'h00;
    keycode1  = 8'h00;
    do_reset();
    chk("reset_x", PaddleX, 10'd20);
    chk("reset_y", PaddleY, 10'd240);
    chk("reset_s", PaddleS, 10'd24);
    chk("reset_vy", PaddleVY, 10'd0);

    // frame_clk stays high after reset: no movement expected
    keycode0 = 8'h1A;
    repeat (10) @(negedge Clk);
    chk("no_tick_y", PaddleY, 10'd240);

    for (int i = 0; i < 8; i++) begin
      frame();
      chk($sformatf("acc_vy%0d", i), PaddleVY, exp_vy_up[i]);
      chk($sformatf("acc_y%0d", i), PaddleY, exp_y_up[i]);
    end

    keycode0 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frame();
      chk($sformatf("brake_vy%0d", i), PaddleVY, exp_vy_br[i]);
    end
    chk("brake_y", PaddleY, 10'd192);
    frame();
    chk("idle_hold_y", PaddleY, 10'd192);
    chk("idle_hold_vy", PaddleVY, 10'd0);

    do_reset();
    keycode1 = 8'h51;
    repeat (38) frame();
    chk("down38_y", PaddleY, 10'd453);
    chk("down38_vy", PaddleVY, 10'd6);
    frame();
    chk("clamp_y", PaddleY, 10'd455);
    chk("clamp_vy", PaddleVY, 10'd0);
    for (int i = 0; i < 2; i++) begin
      frame();
      chk($sformatf("clamp_hold_y%0d", i), PaddleY, 10'd455);
      chk($sformatf("clamp_hold_vy%0d", i), PaddleVY, 10'd0);
    end

    do_reset();
    keycode0 = 8'h1A;
    keycode1 = 8'h16;
    repeat (2) frame();
    chk("both_idle_y", PaddleY, 10'd240);
    chk("both_idle_vy", PaddleVY, 10'd0);
    keycode1 = 8'h00;
    repeat (4) frame();
    chk("up4_y", PaddleY, 10'd230);
    chk("up4_vy", PaddleVY, 10'(-4));
    keycode1 = 8'h16;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk($sformatf("both_brake_vy%0d", i), PaddleVY, 10'(-(3 - i)));
    end
    chk("both_brake_y", PaddleY, 10'd224);

    do_reset();
    keycode0 = 8'h52;
    repeat (3) frame();
    chk("up3_y", PaddleY, 10'd234);
    chk("up3_vy", PaddleVY, 10'(-3));
    keycode0 = 8'h16;
    for (int i = 0; i < 3; i++) begin
      frame();
      chk($sformatf("rev_vy%0d", i), PaddleVY, 10'(-(2 - i)));
    end
    chk("rev_y", PaddleY, 10'd231);
    frame();
    chk("rev_down_vy", PaddleVY, 10'd1);
    chk("rev_down_y", PaddleY, 10'd232);

    do_reset();
    keycode0 = 8'h1A;
    repeat (3) frame();
    chk("pre_rst_y", PaddleY, 10'd234);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_y", PaddleY, 10'd240);
    chk("async_rst_vy", PaddleVY, 10'd0);
    chk("async_rst_x", PaddleX, 10'd20);
    @(negedge Clk);
    Reset_n = 1'b1;
    frame();
    chk("post_rst_vy", PaddleVY, 10'(-1));
    chk("post_rst_y", PaddleY, 10'd239);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
